// File: rtl/riscv_pkg.sv
// Shared constants for the RV32 pipeline: datapath widths and ALU operation codes.
package riscv_pkg;
  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  localparam logic [3:0] ALU_OP_ADD   = 4'd0;
  localparam logic [3:0] ALU_OP_SUB   = 4'd1;
  localparam logic [3:0] ALU_OP_AND   = 4'd2;
  localparam logic [3:0] ALU_OP_OR    = 4'd3;
  localparam logic [3:0] ALU_OP_XOR   = 4'd4;
  localparam logic [3:0] ALU_OP_SLL   = 4'd5;
  localparam logic [3:0] ALU_OP_SRL   = 4'd6;
  localparam logic [3:0] ALU_OP_SRA   = 4'd7;
  localparam logic [3:0] ALU_OP_SLT   = 4'd8;
  localparam logic [3:0] ALU_OP_SLTU  = 4'd9;
  localparam logic [3:0] ALU_OP_PASSB = 4'd10;
endpackage

// File: rtl/ex_alu.sv
// Combinational integer ALU for the execute stage; unlisted op codes fall back to ADD.
module ex_alu #(
  parameter int XLEN = riscv_pkg::XLEN
) (
  input  logic [3:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] result_o,
  output logic            zero_o
);
  import riscv_pkg::*;

  logic [4:0] shamt;
  assign shamt = b_i[4:0];

  always_comb begin
    result_o = a_i + b_i;
    case (op_i)
      ALU_OP_SUB:   result_o = a_i - b_i;
      ALU_OP_AND:   result_o = a_i & b_i;
      ALU_OP_OR:    result_o = a_i | b_i;
      ALU_OP_XOR:   result_o = a_i ^ b_i;
      ALU_OP_SLL:   result_o = a_i << shamt;
      ALU_OP_SRL:   result_o = a_i >> shamt;
      ALU_OP_SRA:   result_o = $unsigned($signed(a_i) >>> shamt);
      ALU_OP_SLT:   result_o = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
      ALU_OP_SLTU:  result_o = {{(XLEN-1){1'b0}}, a_i < b_i};
      ALU_OP_PASSB: result_o = b_i;
      default:      result_o = a_i + b_i;
    endcase
  end

  assign zero_o = (result_o == '0);
endmodule

// File: rtl/ex_mem_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution and the EX/MEM register.
module ex_mem_stage #(
  parameter int XLEN       = riscv_pkg::XLEN,
  parameter int REG_ADDR_W = riscv_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  logic                  Branch_in,
  input  logic                  Mem_Read_in,
  input  logic                  Mem_to_Reg_in,
  input  logic                  Mem_Write_in,
  input  logic                  Reg_Write_in,
  input  logic                  jal_in,
  input  logic                  jalr_in,
  input  logic                  ALU_Src_in,
  input  logic [3:0]            ALU_OP_in,
  input  logic [REG_ADDR_W-1:0] rs1_in,
  input  logic [REG_ADDR_W-1:0] rs2_in,
  input  logic [XLEN-1:0]       rd_in,
  input  logic [XLEN-1:0]       A_in,
  input  logic [XLEN-1:0]       B_in,
  input  logic [XLEN-1:0]       Immediate_in,
  input  logic [XLEN-1:0]       pc_in,
  input  logic                  wb_Reg_Write,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  redirect,
  output logic [XLEN-1:0]       target_pc,
  output logic                  Mem_Read_out,
  output logic                  Mem_to_Reg_out,
  output logic                  Mem_Write_out,
  output logic                  Reg_Write_out,
  output logic [XLEN-1:0]       alu_result_out,
  output logic [XLEN-1:0]       store_data_out,
  output logic [REG_ADDR_W-1:0] rd_out
);
  import riscv_pkg::*;

  logic                  mem_read_q, mem_to_reg_q, mem_write_q, reg_write_q;
  logic [XLEN-1:0]       alu_result_q, store_data_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       alu_result_d;

  logic [XLEN-1:0] fwd_a, fwd_b, op_b, alu_res, jalr_sum;
  logic            alu_zero, branch_taken, exm_fwd_ok;
  logic [REG_ADDR_W-1:0] rd_idx;

  // Upper destination bits are carried by ID/EX but never meaningful here.
  logic unused_rd_hi;
  assign unused_rd_hi = ^rd_in[XLEN-1:REG_ADDR_W];
  assign rd_idx       = rd_in[REG_ADDR_W-1:0];

  // A load in EX/MEM has no data yet; the hazard unit stalls that case upstream.
  assign exm_fwd_ok = reg_write_q && !mem_to_reg_q;

  always_comb begin
    fwd_a = A_in;
    if (rs1_in != '0 && exm_fwd_ok && rd_q == rs1_in)        fwd_a = alu_result_q;
    else if (rs1_in != '0 && wb_Reg_Write && wb_rd == rs1_in) fwd_a = wb_data;
  end

  always_comb begin
    fwd_b = B_in;
    if (rs2_in != '0 && exm_fwd_ok && rd_q == rs2_in)        fwd_b = alu_result_q;
    else if (rs2_in != '0 && wb_Reg_Write && wb_rd == rs2_in) fwd_b = wb_data;
  end

  assign op_b = ALU_Src_in ? Immediate_in : fwd_b;

  ex_alu #(.XLEN(XLEN)) u_alu (
    .op_i    (ALU_OP_in),
    .a_i     (fwd_a),
    .b_i     (op_b),
    .result_o(alu_res),
    .zero_o  (alu_zero)
  );

  always_comb begin
    branch_taken = 1'b0;
    if (Branch_in) begin
      case (ALU_OP_in)
        ALU_OP_SUB:              branch_taken = alu_zero;
        ALU_OP_XOR:              branch_taken = !alu_zero;
        ALU_OP_SLT, ALU_OP_SLTU: branch_taken = alu_res[0];
        default:                 branch_taken = 1'b0;
      endcase
    end
  end

  assign jalr_sum  = fwd_a + Immediate_in;
  assign redirect  = jal_in | jalr_in | branch_taken;
  assign target_pc = jalr_in ? {jalr_sum[XLEN-1:1], 1'b0} : pc_in + Immediate_in;

  assign alu_result_d = (jal_in | jalr_in) ? pc_in + XLEN'(4) : alu_res;

  // The rest of the pipeline advances on the falling edge.
  always_ff @(negedge clk or posedge reset) begin
    if (reset) begin
      mem_read_q   <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      reg_write_q  <= 1'b0;
      alu_result_q <= '0;
      store_data_q <= '0;
      rd_q         <= '0;
    end else if (!hold) begin
      mem_read_q   <= Mem_Read_in;
      mem_to_reg_q <= Mem_to_Reg_in;
      mem_write_q  <= Mem_Write_in;
      reg_write_q  <= Reg_Write_in;
      alu_result_q <= alu_result_d;
      store_data_q <= fwd_b;
      rd_q         <= rd_idx;
    end
  end

  assign Mem_Read_out   = mem_read_q;
  assign Mem_to_Reg_out = mem_to_reg_q;
  assign Mem_Write_out  = mem_write_q;
  assign Reg_Write_out  = reg_write_q;
  assign alu_result_out = alu_result_q;
  assign store_data_out = store_data_q;
  assign rd_out         = rd_q;
endmodule
